// File: rtl/text_overlay_pkg.sv
// Shared field codes, tile rows, pair-to-column map and one-hot field encodings
// for the clock text overlay; also used by the overlay renderer.
package text_overlay_pkg;

   typedef enum logic [1:0] {
      FIELD_FECHA = 2'd0,
      FIELD_HORA  = 2'd1,
      FIELD_CRONO = 2'd2
   } field_e;

   localparam logic [4:0] ROW_FECHA = 5'd2;
   localparam logic [4:0] ROW_HORA  = 5'd5;
   localparam logic [4:0] ROW_CRONO = 5'd8;

   localparam logic [5:0] COL_PAIR0      = 6'd3;
   localparam logic [5:0] COL_PAIR1      = 6'd6;
   localparam logic [5:0] COL_PAIR2      = 6'd9;
   // Year pair sits after the fixed "20" prefix
   localparam logic [5:0] COL_FECHA_PAIR2 = 6'd11;

   localparam logic [2:0] SEL_NONE  = 3'b000;
   localparam logic [2:0] SEL_FECHA = 3'b100;
   localparam logic [2:0] SEL_HORA  = 3'b010;
   localparam logic [2:0] SEL_CRONO = 3'b001;

   function automatic field_e field_next(input field_e f);
      case (f)
         FIELD_FECHA: field_next = FIELD_HORA;
         FIELD_HORA:  field_next = FIELD_CRONO;
         default:     field_next = FIELD_FECHA;
      endcase
   endfunction

   function automatic field_e field_prev(input field_e f);
      case (f)
         FIELD_FECHA: field_prev = FIELD_CRONO;
         FIELD_HORA:  field_prev = FIELD_FECHA;
         default:     field_prev = FIELD_HORA;
      endcase
   endfunction

   function automatic logic [2:0] field_onehot(input field_e f);
      case (f)
         FIELD_FECHA: field_onehot = SEL_FECHA;
         FIELD_HORA:  field_onehot = SEL_HORA;
         default:     field_onehot = SEL_CRONO;
      endcase
   endfunction

   function automatic logic [4:0] field_row(input field_e f);
      case (f)
         FIELD_FECHA: field_row = ROW_FECHA;
         FIELD_HORA:  field_row = ROW_HORA;
         default:     field_row = ROW_CRONO;
      endcase
   endfunction

   function automatic logic [5:0] pair_col(input field_e f, input logic [1:0] p);
      case (p)
         2'd0:    pair_col = COL_PAIR0;
         2'd1:    pair_col = COL_PAIR1;
         default: pair_col = (f == FIELD_FECHA) ? COL_FECHA_PAIR2 : COL_PAIR2;
      endcase
   endfunction

endpackage

// File: rtl/text_cursor_ctrl_blink_timer.sv
// Frame-tick divider: toggles o_phase every DIV enabled ticks and pulses o_wrap
// on the tick that completes a period. i_restart forces count 0, phase 1.
module blink_timer #(
   parameter int DIV = 30
) (
   input  logic clk,
   input  logic reset,
   input  logic i_en,
   input  logic i_tick,
   input  logic i_restart,
   output logic o_phase,
   output logic o_wrap
);
   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] r_cnt;
   logic          r_phase;
   logic          w_at_last;

   assign w_at_last = (r_cnt == LAST);
   assign o_phase   = r_phase;
   assign o_wrap    = i_en & i_tick & ~i_restart & w_at_last;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt   <= '0;
         r_phase <= 1'b0;
      end else if (i_restart) begin
         r_cnt   <= '0;
         r_phase <= 1'b1;
      end else if (i_en && i_tick) begin
         if (w_at_last) begin
            r_cnt   <= '0;
            r_phase <= ~r_phase;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/text_cursor_ctrl.sv
// Edit-cursor sequencer for the clock text overlay. Define CURSOR_TIMEOUT_EN to
// build the inactivity timer that leaves EDIT after TIMEOUT_FRAMES idle frames.
module text_cursor_ctrl
   import text_overlay_pkg::*;
#(
   parameter int BLINK_FRAMES   = 30,
   parameter int TIMEOUT_FRAMES = 600
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       frame_tick,
   input  logic       btn_edit,
   input  logic       btn_next,
   input  logic       btn_prev,
   output logic       edit_mode,
   output logic [2:0] field_sel,
   output logic [1:0] pair_sel,
   output logic [4:0] cursor_row,
   output logic [5:0] cursor_col,
   output logic       cursor_on
);
   typedef enum logic {ST_IDLE = 1'b0, ST_EDIT = 1'b1} state_e;

   state_e     r_state;
   field_e     r_field;
   logic [1:0] r_pair;
   logic [2:0] r_field_sel;
   logic [1:0] r_pair_sel;
   logic [4:0] r_row;
   logic [5:0] r_col;

   logic   w_in_edit, w_fwd, w_back, w_blink_restart, w_phase, w_unused_blink_wrap;
   logic   w_timeout;
   field_e w_nxt_field;
   logic [1:0] w_nxt_pair;

   assign w_in_edit = (r_state == ST_EDIT);
   // btn_edit dominates; next+prev together cancel out
   assign w_fwd  = btn_next & ~btn_prev & ~btn_edit;
   assign w_back = btn_prev & ~btn_next & ~btn_edit;
   assign w_blink_restart = (~w_in_edit & btn_edit) | (w_in_edit & (w_fwd | w_back));

   blink_timer #(.DIV(BLINK_FRAMES)) u_blink (
      .clk       (clk),
      .reset     (reset),
      .i_en      (w_in_edit),
      .i_tick    (frame_tick),
      .i_restart (w_blink_restart),
      .o_phase   (w_phase),
      .o_wrap    (w_unused_blink_wrap)
   );

`ifdef CURSOR_TIMEOUT_EN
   logic w_unused_timeout_phase;
   blink_timer #(.DIV(TIMEOUT_FRAMES)) u_timeout (
      .clk       (clk),
      .reset     (reset),
      .i_en      (w_in_edit),
      .i_tick    (frame_tick),
      .i_restart (btn_edit | btn_next | btn_prev),
      .o_phase   (w_unused_timeout_phase),
      .o_wrap    (w_timeout)
   );
`else
   localparam int unused_timeout_frames = TIMEOUT_FRAMES;
   assign w_timeout = 1'b0;
`endif

   always_comb begin
      w_nxt_field = r_field;
      w_nxt_pair  = r_pair;
      if (w_fwd) begin
         if (r_pair == 2'd2) begin
            w_nxt_pair  = 2'd0;
            w_nxt_field = field_next(r_field);
         end else begin
            w_nxt_pair = r_pair + 2'd1;
         end
      end else if (w_back) begin
         if (r_pair == 2'd0) begin
            w_nxt_pair  = 2'd2;
            w_nxt_field = field_prev(r_field);
         end else begin
            w_nxt_pair = r_pair - 2'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_field     <= FIELD_HORA;
         r_pair      <= 2'd0;
         r_field_sel <= SEL_NONE;
         r_pair_sel  <= 2'd0;
         r_row       <= 5'd0;
         r_col       <= 6'd0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (btn_edit) begin
                  r_state     <= ST_EDIT;
                  r_field     <= FIELD_HORA;
                  r_pair      <= 2'd0;
                  r_field_sel <= SEL_HORA;
                  r_pair_sel  <= 2'd0;
                  r_row       <= ROW_HORA;
                  r_col       <= COL_PAIR0;
               end
            end
            default: begin
               // Leaving EDIT keeps row/col so the renderer sees a stable position
               if (btn_edit || w_timeout) begin
                  r_state     <= ST_IDLE;
                  r_field_sel <= SEL_NONE;
               end else if (w_fwd || w_back) begin
                  r_field     <= w_nxt_field;
                  r_pair      <= w_nxt_pair;
                  r_field_sel <= field_onehot(w_nxt_field);
                  r_pair_sel  <= w_nxt_pair;
                  r_row       <= field_row(w_nxt_field);
                  r_col       <= pair_col(w_nxt_field, w_nxt_pair);
               end
            end
         endcase
      end
   end

   assign edit_mode  = w_in_edit;
   assign field_sel  = r_field_sel;
   assign pair_sel   = r_pair_sel;
   assign cursor_row = r_row;
   assign cursor_col = r_col;
   assign cursor_on  = w_in_edit & w_phase;

endmodule
